// File: rtl/clk_div_cfg_ctrl.sv
// Configuration front-end for the integer clock divider: queues ratio requests,
// rejects zero, and replays them to the divider port under a per-transfer timeout.
module clk_div_cfg_ctrl #(
  parameter int DIV_VALUE_WIDTH   = 4,
  parameter int DEFAULT_DIV_VALUE = 2,
  parameter int FIFO_DEPTH        = 2,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [DIV_VALUE_WIDTH-1:0]         req_div_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  output logic [DIV_VALUE_WIDTH-1:0]         div_o,
  output logic                               div_valid_o,
  input  logic                               div_ready_i,
  output logic [DIV_VALUE_WIDTH-1:0]         cur_div_o,
  output logic                               busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o,
  output logic                               err_zero_o,
  output logic                               err_timeout_o,
  input  logic                               err_clr_i
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [LVL_W-1:0]           LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]           PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DIV_VALUE_WIDTH-1:0] DIV_DEF  = DIV_VALUE_WIDTH'(DEFAULT_DIV_VALUE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic [DIV_VALUE_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [LVL_W-1:0]           r_level;
  logic [CNT_W-1:0]           r_cnt;
  logic [DIV_VALUE_WIDTH-1:0] r_div;
  logic [DIV_VALUE_WIDTH-1:0] r_cur;
  logic                       r_err_zero;
  logic                       r_err_timeout;

  logic                       w_ready;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_zero;
  logic                       w_pop;
  logic                       w_done;
  logic                       w_timeout;

  // Ready comes from the registered level only; a full FIFO never accepts,
  // even on a cycle where it is popping.
  assign w_ready  = (r_level != LVL_FULL);
  assign w_accept = req_valid_i & w_ready;
  assign w_push   = w_accept & (req_div_i != '0);
  assign w_zero   = w_accept & (req_div_i == '0);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        // A ready on the terminal-count edge takes priority over the timeout.
        if (div_ready_i) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= req_div_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_div <= DIV_DEF;
      r_cur <= DIV_DEF;
    end else begin
      if (w_pop) begin
        r_cnt <= '0;
        r_div <= r_mem[r_rd_ptr];
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_cur <= r_div;
      end
    end
  end

  // Sticky flags: a new event on the clear cycle keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_zero    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_zero) begin
        r_err_zero <= 1'b1;
      end else if (err_clr_i) begin
        r_err_zero <= 1'b0;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end else if (err_clr_i) begin
        r_err_timeout <= 1'b0;
      end
    end
  end

  assign req_ready_o   = w_ready;
  assign div_o         = r_div;
  assign div_valid_o   = (r_state == S_REQ);
  assign cur_div_o     = r_cur;
  assign busy_o        = (r_level != '0) | (r_state != S_IDLE);
  assign fifo_level_o  = r_level;
  assign err_zero_o    = r_err_zero;
  assign err_timeout_o = r_err_timeout;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: directed table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_clk_div_cfg_ctrl;

  localparam int W     = 4;
  localparam int DEF   = 2;
  localparam int DEPTH = 2;
  localparam int TMO   = 64;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [W-1:0] req_div_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [W-1:0] div_o;
  logic         div_valid_o;
  logic         div_ready_i;
  logic [W-1:0] cur_div_o;
  logic         busy_o;
  logic [1:0]   fifo_level_o;
  logic         err_zero_o;
  logic         err_timeout_o;
  logic         err_clr_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clk_div_cfg_ctrl #(
    .DIV_VALUE_WIDTH  (W),
    .DEFAULT_DIV_VALUE(DEF),
    .FIFO_DEPTH       (DEPTH),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_div_i    (req_div_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .div_o        (div_o),
    .div_valid_o  (div_valid_o),
    .div_ready_i  (div_ready_i),
    .cur_div_o    (cur_div_o),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o),
    .err_zero_o   (err_zero_o),
    .err_timeout_o(err_timeout_o),
    .err_clr_i    (err_clr_i)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         dr;
    logic         clr;
    logic         e_valid;
    logic [W-1:0] e_div;
    logic [W-1:0] e_cur;
    int           e_lvl;
    logic         e_rdy;
    logic         e_ez;
    logic         e_busy;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic v, int d, logic dr, logic clr, logic ev,
                              int ediv, int ecur, int elvl, logic erdy,
                              logic eez, logic ebusy);
    vec_t r;
    r.v = v; r.d = W'(d); r.dr = dr; r.clr = clr;
    r.e_valid = ev; r.e_div = W'(ediv); r.e_cur = W'(ecur); r.e_lvl = elvl;
    r.e_rdy = erdy; r.e_ez = eez; r.e_busy = ebusy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_valid_i = 1'b0;
    req_div_i   = '0;
    div_ready_i = 1'b0;
    err_clr_i   = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Reference model: pending requests as a queue, the in-flight transfer as
  // a flag plus count of valid cycles seen so far.
  int m_q[$];
  bit m_active;
  int m_vcnt;
  int m_div;
  int m_cur;
  bit m_ez;
  bit m_et;

  task automatic model_edge(input bit rst, input bit v, input int d,
                            input bit dr, input bit clr);
    bit acc;
    bit zero_evt;
    bit to_evt;
    if (rst) begin
      m_q.delete();
      m_active = 0; m_vcnt = 0; m_div = DEF; m_cur = DEF; m_ez = 0; m_et = 0;
      return;
    end
    acc      = v && (m_q.size() < DEPTH);
    zero_evt = acc && (d == 0);
    to_evt   = 0;
    if (m_active) begin
      if (dr) begin
        m_cur = m_div;
        m_active = 0;
      end else if (m_vcnt == TMO) begin
        to_evt = 1;
        m_active = 0;
      end else begin
        m_vcnt++;
      end
    end else if (m_q.size() > 0) begin
      m_div = m_q.pop_front();
      m_active = 1;
      m_vcnt = 1;
    end
    if (acc && d != 0) m_q.push_back(d);
    if (clr) begin
      m_ez = 0;
      m_et = 0;
    end
    if (zero_evt) m_ez = 1;
    if (to_evt) m_et = 1;
  endtask

  task automatic compare_model;
    chk("rnd_req_ready", 32'(req_ready_o), 32'(m_q.size() < DEPTH));
    chk("rnd_div_valid", 32'(div_valid_o), 32'(m_active));
    chk("rnd_div", 32'(div_o), 32'(m_div));
    chk("rnd_cur_div", 32'(cur_div_o), 32'(m_cur));
    chk("rnd_busy", 32'(busy_o), 32'((m_q.size() > 0) || m_active));
    chk("rnd_level", 32'(fifo_level_o), 32'(m_q.size()));
    chk("rnd_err_zero", 32'(err_zero_o), 32'(m_ez));
    chk("rnd_err_timeout", 32'(err_timeout_o), 32'(m_et));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit stale;
    int mode;
    bit r_rst, r_v, r_dr, r_clr;
    int r_d;

    tbl[0]  = mk(1, 15, 1, 0, 0,  2,  2, 1, 1, 0, 1);
    tbl[1]  = mk(0,  0, 1, 0, 1, 15,  2, 0, 1, 0, 1);
    tbl[2]  = mk(0,  0, 1, 0, 0, 15, 15, 0, 1, 0, 0);
    tbl[3]  = mk(1,  0, 1, 0, 0, 15, 15, 0, 1, 1, 0);
    tbl[4]  = mk(0,  0, 1, 1, 0, 15, 15, 0, 1, 0, 0);
    tbl[5]  = mk(1,  4, 0, 0, 0, 15, 15, 1, 1, 0, 1);
    tbl[6]  = mk(1,  7, 0, 0, 1,  4, 15, 1, 1, 0, 1);
    tbl[7]  = mk(1,  9, 0, 0, 1,  4, 15, 2, 0, 0, 1);
    tbl[8]  = mk(1,  5, 0, 0, 1,  4, 15, 2, 0, 0, 1);
    tbl[9]  = mk(0,  0, 1, 0, 0,  4,  4, 2, 0, 0, 1);
    tbl[10] = mk(0,  0, 1, 0, 1,  7,  4, 1, 1, 0, 1);
    tbl[11] = mk(0,  0, 1, 0, 0,  7,  7, 1, 1, 0, 1);
    tbl[12] = mk(0,  0, 1, 0, 1,  9,  7, 0, 1, 0, 1);
    tbl[13] = mk(0,  0, 1, 0, 0,  9,  9, 0, 1, 0, 0);
    tbl[14] = mk(1,  0, 0, 1, 0,  9,  9, 0, 1, 1, 0);
    tbl[15] = mk(0,  0, 0, 1, 0,  9,  9, 0, 1, 0, 0);

    rst_i = 1'b0;
    do_reset();
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_div", 32'(div_o), 32'(DEF));
    chk("rst_div_valid", 32'(div_valid_o), 32'd0);
    chk("rst_cur_div", 32'(cur_div_o), 32'(DEF));
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_level", 32'(fifo_level_o), 32'd0);
    chk("rst_err_zero", 32'(err_zero_o), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout_o), 32'd0);

    for (int i = 0; i < 16; i++) begin
      req_valid_i = tbl[i].v;
      req_div_i   = tbl[i].d;
      div_ready_i = tbl[i].dr;
      err_clr_i   = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(div_valid_o), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_div", i), 32'(div_o), 32'(tbl[i].e_div));
      chk($sformatf("tbl%0d_cur", i), 32'(cur_div_o), 32'(tbl[i].e_cur));
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level_o), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_err_zero", i), 32'(err_zero_o), 32'(tbl[i].e_ez));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_err_timeout", i), 32'(err_timeout_o), 32'd0);
      $display("vector %0d: v=%0d d=%0d dr=%0d clr=%0d -> valid=%0d div=%0d cur=%0d lvl=%0d",
               i, tbl[i].v, tbl[i].d, tbl[i].dr, tbl[i].clr,
               div_valid_o, div_o, cur_div_o, fifo_level_o);
    end

    // Timeout: valid must stay up for exactly TMO cycles.
    do_reset();
    req_valid_i = 1'b1; req_div_i = 4'd6;
    step();
    idle_inputs();
    step();
    chk("to_first_valid", 32'(div_valid_o), 32'd1);
    cnt = 1;
    while (div_valid_o && cnt < 200) begin
      step();
      if (div_valid_o) cnt++;
    end
    chk("to_valid_len", 32'(cnt), 32'(TMO));
    chk("to_err_timeout", 32'(err_timeout_o), 32'd1);
    chk("to_cur_div", 32'(cur_div_o), 32'(DEF));
    chk("to_busy", 32'(busy_o), 32'd0);
    $display("timeout sequence: valid cycles=%0d err_timeout=%0d cur=%0d", cnt, err_timeout_o, cur_div_o);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("to_clr", 32'(err_timeout_o), 32'd0);

    // Ready on the last allowed valid cycle wins over the timeout.
    do_reset();
    req_valid_i = 1'b1; req_div_i = 4'd6;
    step();
    idle_inputs();
    step();
    repeat (TMO - 1) step();
    chk("last_valid_still_high", 32'(div_valid_o), 32'd1);
    div_ready_i = 1'b1;
    step();
    div_ready_i = 1'b0;
    chk("last_ready_valid", 32'(div_valid_o), 32'd0);
    chk("last_ready_cur", 32'(cur_div_o), 32'd6);
    chk("last_ready_err", 32'(err_timeout_o), 32'd0);
    $display("ready-at-terminal sequence: cur=%0d err_timeout=%0d", cur_div_o, err_timeout_o);

    // Reset in the middle of a transfer with a full FIFO.
    do_reset();
    req_valid_i = 1'b1;
    req_div_i = 4'd4; step();
    req_div_i = 4'd7; step();
    req_div_i = 4'd9; step();
    idle_inputs();
    chk("mid_valid", 32'(div_valid_o), 32'd1);
    chk("mid_level", 32'(fifo_level_o), 32'd2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid_rst_valid", 32'(div_valid_o), 32'd0);
    chk("mid_rst_level", 32'(fifo_level_o), 32'd0);
    chk("mid_rst_cur", 32'(cur_div_o), 32'(DEF));
    chk("mid_rst_div", 32'(div_o), 32'(DEF));
    div_ready_i = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      step();
      if (div_valid_o) stale = 1'b1;
    end
    div_ready_i = 1'b0;
    chk("mid_no_stale", 32'(stale), 32'd0);
    chk("mid_cur_after", 32'(cur_div_o), 32'(DEF));
    $display("reset-in-transfer sequence: stale=%0d cur=%0d", stale, cur_div_o);

    // Randomized traffic against the reference model.
    rst_i = 1'b1;
    idle_inputs();
    step();
    model_edge(1, 0, 0, 0, 0);
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) mode = int'($urandom_range(0, 2));
      r_rst = ($urandom_range(0, 399) == 0);
      r_v   = ($urandom_range(0, 2) == 0);
      r_d   = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 15));
      case (mode)
        0:       r_dr = ($urandom_range(0, 1) == 0);
        1:       r_dr = ($urandom_range(0, 15) == 0);
        default: r_dr = 1'b0;
      endcase
      r_clr = ($urandom_range(0, 19) == 0);
      rst_i       = r_rst;
      req_valid_i = r_v;
      req_div_i   = W'(r_d);
      div_ready_i = r_dr;
      err_clr_i   = r_clr;
      step();
      model_edge(r_rst, r_v, r_d, r_dr, r_clr);
      compare_model();
    end
    rst_i = 1'b0;
    idle_inputs();
    $display("random phase: 4000 cycles, final cur=%0d model cur=%0d", cur_div_o, m_cur);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_div_cfg_ctrl.md
# clk_div_cfg_ctrl

Configuration front-end for the integer clock divider. It accepts divide-ratio requests from the register/config side, buffers them in a small FIFO, rejects illegal values, and replays them one at a time to the divider's valid/ready programming port (`div_o`/`div_valid_o`/`div_ready_i`). Each transfer is supervised by a timeout. The block sits directly upstream of the divider, in the divider's input clock domain, and tracks the ratio currently in force.

## Interface
Parameters:
- DIV_VALUE_WIDTH, 4, width of every divide-value bus.
- DEFAULT_DIV_VALUE, 2, ratio assumed in force after reset; must match the divider's own default.
- FIFO_DEPTH, 2, number of pending requests held (≥1).
- TIMEOUT_CYCLES, 64, maximum cycles `div_valid_o` stays high waiting for `div_ready_i` (≥2).

Ports:
- clk_i  in  1  clock; the divider's input clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_div_i  in  DIV_VALUE_WIDTH  requested divide ratio.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when `req_valid_i & req_ready_o` at a rising edge.
- div_o  out  DIV_VALUE_WIDTH  ratio presented to the divider.
- div_valid_o  out  1  divider programming valid.
- div_ready_i  in  1  divider programming ready.
- cur_div_o  out  DIV_VALUE_WIDTH  last ratio the divider accepted.
- busy_o  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  number of entries in the FIFO.
- err_zero_o  out  1  sticky flag: a request of value 0 was received.
- err_timeout_o  out  1  sticky flag: a transfer timed out.
- err_clr_i  in  1  clears both sticky flags.

## Operation
- Reset values: `req_ready_o`=1, `div_o`=DEFAULT_DIV_VALUE, `div_valid_o`=0, `cur_div_o`=DEFAULT_DIV_VALUE, `busy_o`=0, `fifo_level_o`=0, `err_zero_o`=0, `err_timeout_o`=0. The FSM resets to IDLE and the FIFO and timeout counter are cleared.
- Reset during a transfer (FSM in REQ): the transfer is abandoned, `div_valid_o` is 0 on the cycle after reset, and all pending FIFO entries are discarded.
- Upstream side:
  - `req_ready_o` = FIFO not full, computed from the registered level. There is no same-cycle pop-to-push bypass, so a full FIFO keeps `req_ready_o`=0 even in a cycle where it pops.
  - An accepted nonzero value is written to the FIFO tail.
  - An accepted value of 0 is consumed (handshake completes), not written, and sets `err_zero_o`.
- FSM states IDLE and REQ:
  - IDLE: if the FIFO is non-empty, pop the head into the `div_o` register, clear the timeout counter and go to REQ. Otherwise stay, with `div_valid_o`=0.
  - REQ: `div_valid_o`=1 and `div_o` is held stable. The timeout counter increments every cycle.
    - On a rising edge with `div_ready_i`=1: `cur_div_o` ← `div_o`, go to IDLE.
    - Else, if the counter reaches TIMEOUT_CYCLES-1: set `err_timeout_o`, drop the value (`cur_div_o` unchanged), go to IDLE.
    - A ready arriving on the same edge as the timeout terminal count wins: the transfer succeeds and no error is raised.
- `div_valid_o` never deasserts before the handshake completes, except on timeout or reset.
- `div_o` holds its last value while in IDLE.
- Sticky flags: `err_clr_i` clears them. If a new error event occurs in the same cycle as `err_clr_i`, the set wins.
- Push and pop in the same cycle: `fifo_level_o` is unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Request accepted at edge N → entry visible at N+1 → IDLE pops at edge N+1 → `div_valid_o`=1 from cycle N+2. Minimum latency from request accept to divider valid is 2 cycles.
- Handshake at edge M → `div_valid_o`=0 and `cur_div_o` updated in cycle M+1. The next queued value is presented from cycle M+2, so there is at least one idle cycle between transfers.
- Timeout: `div_valid_o` is high for exactly TIMEOUT_CYCLES cycles, then low. `err_timeout_o` is high from the following cycle.
- `busy_o` and `fifo_level_o` are registered and update one cycle after the causing edge.

## Test plan
- Reset, then request 15 with `div_ready_i` tied to 1 → `div_valid_o` high for 1 cycle with `div_o`=15 two cycles after accept; then `cur_div_o`=15, `busy_o`=0.
- With `div_ready_i`=0, send 4, 7 and 9 back-to-back (FIFO_DEPTH=2) → 4 popped into REQ, 7 and 9 queued; `req_ready_o` drops once level=2. After ready is asserted, transfers complete in order 4, 7, 9, and `cur_div_o` ends at 9.
- Request 0 → `req_ready_o` stays 1, `fifo_level_o` stays 0, `err_zero_o`=1. Then `err_clr_i` pulse → `err_zero_o`=0.
- `div_ready_i` held at 0 after a request of 6 → `div_valid_o` high for exactly 64 cycles, then `err_timeout_o`=1 and `cur_div_o` still 2.
- Ready asserted on exactly the 64th valid cycle → success: `cur_div_o`=6, `err_timeout_o`=0.
- Assert `rst_i` while in REQ with 2 entries queued → next cycle `div_valid_o`=0, `fifo_level_o`=0, `cur_div_o`=2, and no stale transfer afterwards.
